comp_loader: RTL and testbench
==============================

COMP_LOADER -- requirements
Module: comp_loader

Interface
REQ-001 Parameter DIGEST_WORDS, default 8: number of 32-bit words in each digest operand; the block SHALL be verified at the default only.
REQ-002 Parameter RV_WORDS, default 5: number of 32-bit words in each r/v operand; the block SHALL be verified at the default only.
REQ-003 clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 wr_valid  in  1  operand word offered.
REQ-006 wr_ready  out  1  operand word accepted when wr_valid && wr_ready at a clk edge.
REQ-007 wr_sel  in  2  target operand: 00 digest0, 01 digest1, 10 rReg, 11 vReg.
REQ-008 wr_data  in  32  operand word, most-significant word first.
REQ-009 start  in  1  single-cycle request to compare.
REQ-010 mode  in  1  compare select, sampled with start: 0 = r/v, 1 = digests.
REQ-011 clr  in  1  synchronous abort/acknowledge.
REQ-012 digest0, digest1  out  256  registered digest operands.
REQ-013 rReg, vReg  out  160  registered r/v operands.
REQ-014 csr  out  1  registered mode, driven to the downstream comparator.
REQ-015 equal  in  1  comparator result, combinational from the outputs above.
REQ-016 busy, done, match, err  out  1 each  status outputs.

Function
REQ-017 FSM states: IDLE, CMP, DONE. busy SHALL be 1 in CMP only, and done SHALL be 1 in DONE only.
REQ-018 wr_ready SHALL be 1 only in IDLE when the word count of the selected operand is below its limit (8 for digests, 5 for r/v).
REQ-019 An accepted word SHALL shift in as operand <= {operand[W-33:0], wr_data} and increment that operand's count.
REQ-020 When a count reaches its limit, further words to that operand SHALL be refused (wr_ready=0) with no change.
REQ-021 On start in IDLE, csr SHALL latch mode and completeness SHALL be checked using counts registered before that edge. A write in the same cycle SHALL be accepted but SHALL NOT count toward the check.
REQ-022 Complete means both rReg and vReg counts are 5 when mode=0, or both digest counts are 8 when mode=1.
REQ-023 If complete: IDLE->CMP. In CMP, match SHALL latch equal, err SHALL be 0, and the FSM SHALL go to DONE on the next edge.
REQ-024 If incomplete: IDLE->DONE directly, with err=1 and match=0.
REQ-025 Latency: with start sampled at edge N, done SHALL be high after edge N+2 (complete) or after edge N+1 (incomplete).
REQ-026 DONE SHALL hold, with operands and status frozen and start ignored, until clr.
REQ-027 clr in any state SHALL return to IDLE and zero all counts, operands, csr, match and err. clr SHALL win over simultaneous start or write.
REQ-028 start while in CMP or DONE SHALL be ignored.

Reset
REQ-029 While rst=1, state SHALL be IDLE, and all counts, operands, csr, busy, done, match, err and irq SHALL be 0. wr_ready SHALL be 1 once rst deasserts.
REQ-030 rst mid-operation SHALL abort immediately, and no partial result SHALL survive.

Configuration
REQ-031 Macro COMP_LOADER_IRQ_EN defined: output port irq (1 bit) SHALL pulse high for exactly one cycle on every entry to DONE.
REQ-032 COMP_LOADER_IRQ_EN undefined: the irq port and its logic SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-033 Write r = 5 words 0x11111111..0x55555555 and the same to v; start with mode=0 -> csr=0, then done=1, match=1, err=0, 2 edges after start.
REQ-034 Write digest0 = 8 words 0x00000000..0x00000007 and digest1 identical except last word 0x00000008; start with mode=1 -> done=1, match=0, err=0, and digest1[31:0]=0x00000008.
REQ-035 Write only 4 words to rReg, then start with mode=0 -> done=1 1 edge after start, err=1, match=0, busy never 1.
REQ-036 After 8 accepted words to digest0, a 9th word 0xDEADBEEF with wr_sel=00 -> wr_ready=0, and digest0 is unchanged.
REQ-037 Assert start and clr together in IDLE with operands complete -> state stays IDLE and all operands read 0. Assert rst in CMP -> all outputs are 0 immediately.
REQ-038 With COMP_LOADER_IRQ_EN defined, a successful compare -> irq is high for exactly 1 cycle, coincident with the first cycle in which done=1.

Source files
------------

// File: rtl/comp_loader.sv
`default_nettype none
// ============================================================================
// comp_loader: loads digest / r,v operands word-by-word and sequences one
// external compare. Optional irq output enabled by macro COMP_LOADER_IRQ_EN.
// Revision: 1.0
// ============================================================================
module comp_loader #(
  parameter int DIGEST_WORDS = 8,
  parameter int RV_WORDS     = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [1:0]                wr_sel,
  input  logic [31:0]               wr_data,
  input  logic                      start,
  input  logic                      mode,
  input  logic                      clr,
  output logic [DIGEST_WORDS*32-1:0] digest0,
  output logic [DIGEST_WORDS*32-1:0] digest1,
  output logic [RV_WORDS*32-1:0]     rReg,
  output logic [RV_WORDS*32-1:0]     vReg,
  output logic                      csr,
  input  logic                      equal,
  output logic                      busy,
  output logic                      done,
  output logic                      match,
  output logic                      err
`ifdef COMP_LOADER_IRQ_EN
  ,
  output logic                      irq
`endif
);

  localparam int DW  = DIGEST_WORDS * 32;
  localparam int RW  = RV_WORDS * 32;
  localparam int DCW = $clog2(DIGEST_WORDS + 1);
  localparam int RCW = $clog2(RV_WORDS + 1);
  localparam logic [DCW-1:0] DLIM = DCW'(DIGEST_WORDS);
  localparam logic [RCW-1:0] RLIM = RCW'(RV_WORDS);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CMP  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]     state;
  logic [DCW-1:0] cnt_d0, cnt_d1;
  logic [RCW-1:0] cnt_r, cnt_v;
  logic           accept;
  logic           complete;

  always_comb begin
    wr_ready = 1'b0;
    if (state == IDLE) begin
      case (wr_sel)
        2'b00:   wr_ready = (cnt_d0 < DLIM);
        2'b01:   wr_ready = (cnt_d1 < DLIM);
        2'b10:   wr_ready = (cnt_r < RLIM);
        default: wr_ready = (cnt_v < RLIM);
      endcase
    end
  end

  assign accept   = wr_valid && wr_ready && !clr;
  // Completeness uses the pre-edge counts, so a write in the start cycle is excluded.
  assign complete = mode ? ((cnt_d0 == DLIM) && (cnt_d1 == DLIM))
                         : ((cnt_r == RLIM) && (cnt_v == RLIM));
  assign busy     = (state == CMP);
  assign done     = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt_d0  <= '0;
      cnt_d1  <= '0;
      cnt_r   <= '0;
      cnt_v   <= '0;
      digest0 <= '0;
      digest1 <= '0;
      rReg    <= '0;
      vReg    <= '0;
      csr     <= 1'b0;
      match   <= 1'b0;
      err     <= 1'b0;
`ifdef COMP_LOADER_IRQ_EN
      irq     <= 1'b0;
`endif
    end else if (clr) begin
      state   <= IDLE;
      cnt_d0  <= '0;
      cnt_d1  <= '0;
      cnt_r   <= '0;
      cnt_v   <= '0;
      digest0 <= '0;
      digest1 <= '0;
      rReg    <= '0;
      vReg    <= '0;
      csr     <= 1'b0;
      match   <= 1'b0;
      err     <= 1'b0;
`ifdef COMP_LOADER_IRQ_EN
      irq     <= 1'b0;
`endif
    end else begin
`ifdef COMP_LOADER_IRQ_EN
      irq <= 1'b0;
`endif
      if (accept) begin
        case (wr_sel)
          2'b00: begin
            digest0 <= {digest0[DW-33:0], wr_data};
            cnt_d0  <= cnt_d0 + 1'b1;
          end
          2'b01: begin
            digest1 <= {digest1[DW-33:0], wr_data};
            cnt_d1  <= cnt_d1 + 1'b1;
          end
          2'b10: begin
            rReg  <= {rReg[RW-33:0], wr_data};
            cnt_r <= cnt_r + 1'b1;
          end
          default: begin
            vReg  <= {vReg[RW-33:0], wr_data};
            cnt_v <= cnt_v + 1'b1;
          end
        endcase
      end
      case (state)
        IDLE: begin
          if (start) begin
            csr <= mode;
            if (complete) begin
              state <= CMP;
            end else begin
              state <= DONE;
              err   <= 1'b1;
              match <= 1'b0;
`ifdef COMP_LOADER_IRQ_EN
              irq   <= 1'b1;
`endif
            end
          end
        end
        CMP: begin
          match <= equal;
          err   <= 1'b0;
          state <= DONE;
`ifdef COMP_LOADER_IRQ_EN
          irq   <= 1'b1;
`endif
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_comp_loader.sv
`default_nettype none
// ============================================================================
// tb_comp_loader: directed scoreboard bench for comp_loader.
// Revision: 1.0
// ============================================================================
module tb_comp_loader;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_valid = 1'b0;
  logic         wr_ready;
  logic [1:0]   wr_sel = 2'b00;
  logic [31:0]  wr_data = '0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic         clr = 1'b0;
  logic [255:0] digest0, digest1;
  logic [159:0] rReg, vReg;
  logic         csr, equal, busy, done, match, err;
`ifdef COMP_LOADER_IRQ_EN
  logic         irq;
`endif

  always #5 clk = ~clk;

  // Downstream comparator as seen by the block.
  assign equal = csr ? (digest0 == digest1) : (rReg == vReg);

  comp_loader dut (
    .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_sel(wr_sel), .wr_data(wr_data), .start(start), .mode(mode),
    .clr(clr), .digest0(digest0), .digest1(digest1), .rReg(rReg),
    .vReg(vReg), .csr(csr), .equal(equal), .busy(busy), .done(done),
    .match(match), .err(err)
`ifdef COMP_LOADER_IRQ_EN
    , .irq(irq)
`endif
  );

  typedef struct {
    logic match_e;
    logic err_e;
    logic csr_e;
    int   lat_e;
  } exp_t;

  exp_t         sb[$];
  int           errors = 0;
  int           checks = 0;
  logic [255:0] m_d0 = '0, m_d1 = '0;
  logic [159:0] m_r = '0, m_v = '0;
  int           cnt[4] = '{0, 0, 0, 0};
  int           lim[4] = '{8, 8, 5, 5};

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_zero();
    m_d0 = '0; m_d1 = '0; m_r = '0; m_v = '0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
  endtask

  task automatic model_shift(input logic [1:0] sel, input logic [31:0] data);
    cnt[sel]++;
    case (sel)
      2'b00:   m_d0 = {m_d0[223:0], data};
      2'b01:   m_d1 = {m_d1[223:0], data};
      2'b10:   m_r  = {m_r[127:0], data};
      default: m_v  = {m_v[127:0], data};
    endcase
  endtask

  task automatic chk_ops(input string tag);
    chk({tag, ".digest0"}, digest0, m_d0);
    chk({tag, ".digest1"}, digest1, m_d1);
    chk({tag, ".rReg"}, rReg, m_r);
    chk({tag, ".vReg"}, vReg, m_v);
  endtask

  // Entered at a negedge in IDLE; leaves at the following negedge.
  task automatic wr(input logic [1:0] sel, input logic [31:0] data);
    logic exp;
    exp = (cnt[sel] < lim[sel]);
    wr_sel = sel; wr_data = data; wr_valid = 1'b1;
    #1 chk("wr_ready", wr_ready, exp);
    @(negedge clk);
    wr_valid = 1'b0;
    if (exp) model_shift(sel, data);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_zero();
  endtask

  task automatic load_rv(input int nr, input int nv);
    for (int i = 0; i < nr; i++) wr(2'b10, 32'h11111111 * (i + 1));
    for (int i = 0; i < nv; i++) wr(2'b11, 32'h11111111 * (i + 1));
  endtask

  // Called at the first negedge after the start edge.
  task automatic wait_done();
    int   lat;
    logic busy_seen;
    exp_t e;
    lat = 1;
    busy_seen = 1'b0;
    while (!done && lat < 10) begin
      if (busy) busy_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    chk("done_reached", done, 1'b1);
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 1'b1, 1'b0);
    end else begin
      e = sb.pop_front();
      chk("latency", lat, e.lat_e);
      chk("match", match, e.match_e);
      chk("err", err, e.err_e);
      chk("csr", csr, e.csr_e);
      chk("busy_seen", busy_seen, (e.lat_e == 2));
`ifdef COMP_LOADER_IRQ_EN
      chk("irq_first", irq, 1'b1);
`endif
      @(negedge clk);
      chk("done_hold", done, 1'b1);
`ifdef COMP_LOADER_IRQ_EN
      chk("irq_second", irq, 1'b0);
`endif
    end
  endtask

  task automatic go(input logic m, input logic em, input logic ee, input int elat);
    sb.push_back('{match_e: em, err_e: ee, csr_e: m, lat_e: elat});
    start = 1'b1; mode = m;
    @(negedge clk);
    start = 1'b0;
    wait_done();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset
    @(negedge clk); @(negedge clk);
    chk_ops("reset");
    chk("reset.busy", busy, 1'b0);
    chk("reset.done", done, 1'b0);
    chk("reset.csr", csr, 1'b0);
    chk("reset.match", match, 1'b0);
    chk("reset.err", err, 1'b0);
    rst = 1'b0;
    #1 chk("reset.wr_ready", wr_ready, 1'b1);
    @(negedge clk);

    // r/v compare, equal operands
    load_rv(5, 5);
    chk_ops("rv_load");
    wr(2'b10, 32'hCAFEF00D);
    go(1'b0, 1'b1, 1'b0, 2);
    chk_ops("rv_done");

    // start in DONE is ignored
    start = 1'b1; mode = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_ignore.done", done, 1'b1);
    chk("done_ignore.csr", csr, 1'b0);
    chk("done_ignore.match", match, 1'b1);
    do_clr();
    chk_ops("clr1");
    chk("clr1.done", done, 1'b0);
    chk("clr1.match", match, 1'b0);

    // Digest compare, last word differs; 9th word refused
    for (int i = 0; i < 8; i++) wr(2'b00, 32'(i));
    for (int i = 0; i < 7; i++) wr(2'b01, 32'(i));
    wr(2'b01, 32'h00000008);
    wr(2'b00, 32'hDEADBEEF);
    chk_ops("d_refuse");
    go(1'b1, 1'b0, 1'b0, 2);
    chk("digest1_low", digest1[31:0], 32'h00000008);
    chk_ops("d_done");
    do_clr();

    // Incomplete: only 4 words in rReg
    load_rv(4, 0);
    go(1'b0, 1'b0, 1'b1, 1);
    do_clr();

    // Write in the start cycle is accepted but not counted
    load_rv(5, 4);
    wr_sel = 2'b11; wr_data = 32'h55555555; wr_valid = 1'b1;
    start = 1'b1; mode = 1'b0;
    sb.push_back('{match_e: 1'b0, err_e: 1'b1, csr_e: 1'b0, lat_e: 1});
    @(negedge clk);
    wr_valid = 1'b0; start = 1'b0;
    model_shift(2'b11, 32'h55555555);
    wait_done();
    chk_ops("same_cycle");
    do_clr();

    // start and clr together
    load_rv(5, 5);
    start = 1'b1; clr = 1'b1; mode = 1'b0;
    @(negedge clk);
    start = 1'b0; clr = 1'b0;
    model_zero();
    chk_ops("start_clr");
    chk("start_clr.busy", busy, 1'b0);
    chk("start_clr.done", done, 1'b0);
    @(negedge clk);
    chk("start_clr.busy2", busy, 1'b0);
    chk("start_clr.done2", done, 1'b0);

    // Asynchronous reset while in CMP
    load_rv(5, 5);
    start = 1'b1; mode = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("cmp.busy", busy, 1'b1);
    #1 rst = 1'b1;
    #1;
    model_zero();
    chk_ops("rst_cmp");
    chk("rst_cmp.busy", busy, 1'b0);
    chk("rst_cmp.done", done, 1'b0);
    chk("rst_cmp.csr", csr, 1'b0);
    chk("rst_cmp.match", match, 1'b0);
    chk("rst_cmp.err", err, 1'b0);
`ifdef COMP_LOADER_IRQ_EN
    chk("rst_cmp.irq", irq, 1'b0);
`endif
    @(negedge clk);
    rst = 1'b0;
    wr_sel = 2'b10;
    #1 chk("rst_cmp.wr_ready", wr_ready, 1'b1);
    @(negedge clk);
    chk("rst_cmp.done_after", done, 1'b0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
